// File: rtl/vga_frame_fetch_arbiter.sv
// vga_frame_fetch_arbiter: shares one synchronous single-port game RAM between the CPU and a
// once-per-frame VGA fetch of the ship X / ship Y+status words, published as a tear-free pair.
`default_nettype none

module vga_frame_fetch_arbiter #(
   parameter int                 ADDR_W      = 16,
   parameter int                 DATA_W      = 16,
   parameter logic [ADDR_W-1:0]  SHIP_X_ADDR = 16'h3FF0,
   parameter logic [ADDR_W-1:0]  SHIP_Y_ADDR = 16'h3FF1,
   parameter logic [7:0]         TIMEOUT     = 8'd64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_grant,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] ram_out1,
   output logic [DATA_W-1:0] ram_out2,
   output logic              frame_data_valid,
   output logic              fetch_overrun
);

   // Status word with only the not-started flag set, so the display shows the start screen.
   localparam logic [DATA_W-1:0] OUT2_RST = DATA_W'(16'h1000);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ_X = 3'd1,
      S_CAP_X = 3'd2,
      S_REQ_Y = 3'd3,
      S_CAP_Y = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] shadow_x_q, shadow_x_d;
   logic [DATA_W-1:0] ram_out1_q, ram_out1_d;
   logic [DATA_W-1:0] ram_out2_q, ram_out2_d;
   logic              frame_valid_q, frame_valid_d;
   logic              overrun_q, overrun_d;
   logic              rvalid_q, rvalid_d;

   logic              in_req;
   logic              vga_win;

   // The VGA side only competes in the two request states; the CPU owns the port otherwise.
   always_comb begin
      in_req    = (state_q == S_REQ_X) || (state_q == S_REQ_Y);
      vga_win   = in_req && (!cpu_req || (wait_cnt_q == TIMEOUT));
      cpu_grant = cpu_req && !vga_win;
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (vga_win) begin
         mem_addr = (state_q == S_REQ_X) ? SHIP_X_ADDR : SHIP_Y_ADDR;
      end else if (cpu_grant) begin
         mem_addr  = cpu_addr;
         mem_we    = cpu_we;
         mem_wdata = cpu_wdata;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      shadow_x_d    = shadow_x_q;
      ram_out1_d    = ram_out1_q;
      ram_out2_d    = ram_out2_q;
      frame_valid_d = 1'b0;
      overrun_d     = overrun_q | (frame_start && (state_q != S_IDLE));
      rvalid_d      = cpu_grant && !cpu_we;

      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d    = S_REQ_X;
               wait_cnt_d = 8'd0;
            end
         end
         S_REQ_X: begin
            // Losing here implies wait_cnt is below TIMEOUT, so the count saturates by itself.
            if (vga_win) state_d = S_CAP_X;
            else         wait_cnt_d = wait_cnt_q + 8'd1;
         end
         S_CAP_X: begin
            shadow_x_d = mem_rdata;
            state_d    = S_REQ_Y;
         end
         S_REQ_Y: begin
            if (vga_win) state_d = S_CAP_Y;
            else         wait_cnt_d = wait_cnt_q + 8'd1;
         end
         S_CAP_Y: begin
            ram_out1_d    = shadow_x_q;
            ram_out2_d    = mem_rdata;
            frame_valid_d = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         wait_cnt_q    <= 8'd0;
         shadow_x_q    <= '0;
         ram_out1_q    <= '0;
         ram_out2_q    <= OUT2_RST;
         frame_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
         rvalid_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         shadow_x_q    <= shadow_x_d;
         ram_out1_q    <= ram_out1_d;
         ram_out2_q    <= ram_out2_d;
         frame_valid_q <= frame_valid_d;
         overrun_q     <= overrun_d;
         rvalid_q      <= rvalid_d;
      end
   end

   assign cpu_rdata        = mem_rdata;
   assign cpu_rvalid       = rvalid_q;
   assign ram_out1         = ram_out1_q;
   assign ram_out2         = ram_out2_q;
   assign frame_data_valid = frame_valid_q;
   assign fetch_overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_fetch_arbiter.sv
// tb_vga_frame_fetch_arbiter: directed scenarios against a behavioural synchronous RAM model.
`default_nettype none

module tb_vga_frame_fetch_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_start = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [15:0] cpu_wdata = 16'h0000;
   logic        cpu_grant;
   logic [15:0] cpu_rdata;
   logic        cpu_rvalid;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0000;
   logic [15:0] ram_out1;
   logic [15:0] ram_out2;
   logic        frame_data_valid;
   logic        fetch_overrun;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] ram [0:65535];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   vga_frame_fetch_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .frame_start      (frame_start),
      .cpu_req          (cpu_req),
      .cpu_we           (cpu_we),
      .cpu_addr         (cpu_addr),
      .cpu_wdata        (cpu_wdata),
      .cpu_grant        (cpu_grant),
      .cpu_rdata        (cpu_rdata),
      .cpu_rvalid       (cpu_rvalid),
      .mem_addr         (mem_addr),
      .mem_we           (mem_we),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .ram_out1         (ram_out1),
      .ram_out2         (ram_out2),
      .frame_data_valid (frame_data_valid),
      .fetch_overrun    (fetch_overrun)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      next_cycle();
      cpu_req = 1'b0; cpu_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) next_cycle();
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (ram_out1 !== 16'h0000) begin n_err++; $display("FAIL reset_out1 got %h want 0000", ram_out1); end
      n_cmp++; if (ram_out2 !== 16'h1000) begin n_err++; $display("FAIL reset_out2 got %h want 1000", ram_out2); end
      n_cmp++; if (frame_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_fdv got %b want 0", frame_data_valid); end
      n_cmp++; if (fetch_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", fetch_overrun); end
      n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", cpu_rvalid); end
      n_cmp++; if (mem_addr !== 16'h0000 || mem_we !== 1'b0) begin n_err++; $display("FAIL reset_idle_port got addr %h we %b want 0000/0", mem_addr, mem_we); end
      next_cycle();
   endtask

   task automatic test_cpu_rw();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hBEEF;
      @(negedge clk);
      n_cmp++; if (cpu_grant !== 1'b1) begin n_err++; $display("FAIL cpu_wr_grant got %b want 1", cpu_grant); end
      n_cmp++; if (mem_addr !== 16'h0100 || mem_we !== 1'b1 || mem_wdata !== 16'hBEEF) begin n_err++; $display("FAIL cpu_wr_port got %h/%b/%h want 0100/1/beef", mem_addr, mem_we, mem_wdata); end
      next_cycle();
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk);
      n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL cpu_wr_no_rvalid got %b want 0", cpu_rvalid); end
      next_cycle();
      cpu_req = 1'b1; cpu_addr = 16'h0100;
      @(negedge clk);
      n_cmp++; if (cpu_grant !== 1'b1) begin n_err++; $display("FAIL cpu_rd_grant got %b want 1", cpu_grant); end
      next_cycle();
      cpu_req = 1'b0;
      @(negedge clk);
      n_cmp++; if (cpu_rvalid !== 1'b1) begin n_err++; $display("FAIL cpu_rd_rvalid got %b want 1", cpu_rvalid); end
      n_cmp++; if (cpu_rdata !== 16'hBEEF) begin n_err++; $display("FAIL cpu_rd_data got %h want beef", cpu_rdata); end
      next_cycle();
      @(negedge clk);
      n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL cpu_rd_rvalid_drop got %b want 0", cpu_rvalid); end
      next_cycle();
   endtask

   task automatic test_idle_fetch();
      cpu_write(16'h3FF0, 16'h0064);
      cpu_write(16'h3FF1, 16'h00C8);
      frame_start = 1'b1;
      next_cycle();
      frame_start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) begin
            n_cmp++; if (mem_addr !== 16'h3FF0 || mem_we !== 1'b0) begin n_err++; $display("FAIL idle_x_issue got %h/%b want 3ff0/0", mem_addr, mem_we); end
         end
         if (k == 3) begin
            n_cmp++; if (mem_addr !== 16'h3FF1) begin n_err++; $display("FAIL idle_y_issue got %h want 3ff1", mem_addr); end
         end
         if (k == 4) begin
            n_cmp++; if (frame_data_valid !== 1'b0 || ram_out1 !== 16'h0000) begin n_err++; $display("FAIL idle_early got fdv %b out1 %h want 0/0000", frame_data_valid, ram_out1); end
         end
         if (k == 5) begin
            n_cmp++; if (frame_data_valid !== 1'b1) begin n_err++; $display("FAIL idle_fdv got %b want 1", frame_data_valid); end
            n_cmp++; if (ram_out1 !== 16'h0064 || ram_out2 !== 16'h00C8) begin n_err++; $display("FAIL idle_outs got %h/%h want 0064/00c8", ram_out1, ram_out2); end
         end
         if (k == 6) begin
            n_cmp++; if (frame_data_valid !== 1'b0) begin n_err++; $display("FAIL idle_fdv_width got %b want 0", frame_data_valid); end
         end
         next_cycle();
      end
   endtask

   task automatic test_contention();
      int denied;
      denied = 0;
      cpu_write(16'h3FF0, 16'h0111);
      cpu_write(16'h3FF1, 16'h0222);
      frame_start = 1'b1;
      next_cycle();
      frame_start = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
      for (int k = 1; k <= 15; k++) begin
         if (k == 11) cpu_req = 1'b0;
         @(negedge clk);
         if (k <= 10 && cpu_grant !== 1'b1) denied++;
         if (k == 11) begin
            n_cmp++; if (mem_addr !== 16'h3FF0 || cpu_grant !== 1'b0) begin n_err++; $display("FAIL cont_x_issue got %h grant %b want 3ff0/0", mem_addr, cpu_grant); end
         end
         if (k == 14) begin
            n_cmp++; if (frame_data_valid !== 1'b0) begin n_err++; $display("FAIL cont_early_fdv got %b want 0", frame_data_valid); end
         end
         if (k == 15) begin
            n_cmp++; if (frame_data_valid !== 1'b1 || ram_out1 !== 16'h0111 || ram_out2 !== 16'h0222) begin n_err++; $display("FAIL cont_outs got fdv %b %h/%h want 1 0111/0222", frame_data_valid, ram_out1, ram_out2); end
         end
         next_cycle();
      end
      n_cmp++; if (denied !== 0) begin n_err++; $display("FAIL cont_cpu_grant got %0d denied cycles want 0", denied); end
   endtask

   task automatic test_starvation();
      int zeros;
      int first_zero;
      int second_zero;
      zeros = 0; first_zero = -1; second_zero = -1;
      cpu_write(16'h3FF0, 16'h0033);
      cpu_write(16'h3FF1, 16'h0044);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
      frame_start = 1'b1;
      next_cycle();
      frame_start = 1'b0;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if (cpu_grant !== 1'b1) begin
            zeros++;
            if (first_zero < 0) first_zero = k;
            else if (second_zero < 0) second_zero = k;
         end
         if (k == 65) begin
            n_cmp++; if (mem_addr !== 16'h3FF0) begin n_err++; $display("FAIL starve_x_addr got %h want 3ff0", mem_addr); end
         end
         if (k == 66) begin
            n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL starve_rvalid got %b want 0", cpu_rvalid); end
         end
         if (k == 67) begin
            n_cmp++; if (mem_addr !== 16'h3FF1) begin n_err++; $display("FAIL starve_y_addr got %h want 3ff1", mem_addr); end
         end
         if (k == 69) begin
            n_cmp++; if (frame_data_valid !== 1'b1 || ram_out1 !== 16'h0033 || ram_out2 !== 16'h0044) begin n_err++; $display("FAIL starve_outs got fdv %b %h/%h want 1 0033/0044", frame_data_valid, ram_out1, ram_out2); end
         end
         next_cycle();
      end
      cpu_req = 1'b0;
      n_cmp++; if (zeros !== 2 || first_zero !== 65 || second_zero !== 67) begin n_err++; $display("FAIL starve_grant_gaps got %0d at %0d,%0d want 2 at 65,67", zeros, first_zero, second_zero); end
   endtask

   task automatic test_overrun();
      int pulses;
      pulses = 0;
      cpu_write(16'h3FF0, 16'h0055);
      cpu_write(16'h3FF1, 16'h0066);
      frame_start = 1'b1;
      next_cycle();
      frame_start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         frame_start = (k == 2);
         @(negedge clk);
         if (frame_data_valid === 1'b1) pulses++;
         if (k == 2) begin
            n_cmp++; if (fetch_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early got %b want 0", fetch_overrun); end
         end
         if (k == 3) begin
            n_cmp++; if (fetch_overrun !== 1'b1 || mem_addr !== 16'h3FF1) begin n_err++; $display("FAIL ovr_set got %b addr %h want 1/3ff1", fetch_overrun, mem_addr); end
         end
         if (k == 12) begin
            n_cmp++; if (fetch_overrun !== 1'b1 || ram_out1 !== 16'h0055 || ram_out2 !== 16'h0066) begin n_err++; $display("FAIL ovr_hold got %b %h/%h want 1 0055/0066", fetch_overrun, ram_out1, ram_out2); end
         end
         next_cycle();
      end
      frame_start = 1'b0;
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL ovr_pulses got %0d want 1", pulses); end
   endtask

   task automatic test_async_reset();
      frame_start = 1'b1;
      next_cycle();
      frame_start = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      n_cmp++; if (mem_addr !== 16'h3FF1) begin n_err++; $display("FAIL areset_in_req_y got %h want 3ff1", mem_addr); end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (ram_out1 !== 16'h0000 || ram_out2 !== 16'h1000) begin n_err++; $display("FAIL areset_outs got %h/%h want 0000/1000", ram_out1, ram_out2); end
      n_cmp++; if (mem_addr !== 16'h0000 || fetch_overrun !== 1'b0 || frame_data_valid !== 1'b0) begin n_err++; $display("FAIL areset_idle got addr %h ovr %b fdv %b want 0000/0/0", mem_addr, fetch_overrun, frame_data_valid); end
      next_cycle();
      reset = 1'b1;
      next_cycle();
      cpu_write(16'h3FF0, 16'h0010);
      cpu_write(16'h3FF1, 16'h0400);
      frame_start = 1'b1;
      next_cycle();
      frame_start = 1'b0;
      repeat (4) next_cycle();
      @(negedge clk);
      n_cmp++; if (frame_data_valid !== 1'b1 || ram_out1 !== 16'h0010 || ram_out2 !== 16'h0400) begin n_err++; $display("FAIL areset_refetch got fdv %b %h/%h want 1 0010/0400", frame_data_valid, ram_out1, ram_out2); end
      next_cycle();
   endtask

   task automatic test_capy_overrun();
      int pulses;
      pulses = 0;
      cpu_write(16'h3FF0, 16'h0077);
      cpu_write(16'h3FF1, 16'h0088);
      frame_start = 1'b1;
      next_cycle();
      for (int k = 1; k <= 10; k++) begin
         frame_start = (k == 4);
         @(negedge clk);
         if (frame_data_valid === 1'b1) pulses++;
         if (k == 5) begin
            n_cmp++; if (fetch_overrun !== 1'b1 || ram_out1 !== 16'h0077 || ram_out2 !== 16'h0088) begin n_err++; $display("FAIL capy_ovr got %b %h/%h want 1 0077/0088", fetch_overrun, ram_out1, ram_out2); end
            n_cmp++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL capy_no_restart got %h want 0000", mem_addr); end
         end
         next_cycle();
      end
      frame_start = 1'b0;
      n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL capy_pulses got %0d want 1", pulses); end
   endtask

   initial begin
      #1;
      test_reset();
      test_cpu_rw();
      test_idle_fetch();
      test_contention();
      test_starvation();
      test_overrun();
      test_async_reset();
      test_capy_overrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/vga_frame_fetch_arbiter.md
Name: vga_frame_fetch_arbiter

Overview:
- Shares one single-port synchronous game RAM between the CPU and the VGA display path.
- Once per frame, on a frame-start pulse, it fetches the two VGA status words: ship X, and ship Y plus the dead/won/not-started flags.
- It presents both words to the VGA block as an atomic, tear-free pair.
- The CPU normally has priority; a starvation counter forces the VGA fetch through if the CPU hogs the port.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 16, RAM data width
SHIP_X_ADDR, 16'h3FF0, RAM address of ship X word (bits [9:0] = X)
SHIP_Y_ADDR, 16'h3FF1, RAM address of ship Y/status word ([9:0] Y, [10] dead, [11] won, [12] not started)
TIMEOUT, 8'd64, lost-arbitration cycles after which the VGA request preempts the CPU

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset
frame_start  input  1  one-clk pulse from VGA timing at start of vertical blank
cpu_req  input  1  CPU requests memory port this cycle
cpu_we  input  1  1 = write, 0 = read (qualified by cpu_req)
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_grant  output  1  combinational; CPU owns port this cycle
cpu_rdata  output  DATA_W  read data, equals mem_rdata
cpu_rvalid  output  1  registered; high the cycle after a granted CPU read
mem_addr  output  ADDR_W  RAM address (combinational mux)
mem_we  output  1  RAM write enable
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM read data, valid 1 clk after address
ram_out1  output  DATA_W  registered ship X word to VGA block
ram_out2  output  DATA_W  registered ship Y/status word to VGA block
frame_data_valid  output  1  one-clk pulse when ram_out1/ram_out2 update
fetch_overrun  output  1  sticky; frame_start arrived while a fetch was in progress

Behaviour:
Reset values (while reset=0, async):
- state=IDLE, wait_cnt=0, shadow_x=0.
- ram_out1=16'h0000, ram_out2=16'h1000, so the display shows the start screen.
- frame_data_valid=0, fetch_overrun=0, cpu_rvalid=0.

States: IDLE, REQ_X, CAP_X, REQ_Y, CAP_Y.
- IDLE: frame_start=1 -> REQ_X, wait_cnt<=0.
- REQ_X: if VGA wins, drive mem_addr=SHIP_X_ADDR, mem_we=0, -> CAP_X; else stay.
- CAP_X: shadow_x<=mem_rdata, -> REQ_Y unconditionally. Port is free for the CPU this cycle.
- REQ_Y: if VGA wins, drive mem_addr=SHIP_Y_ADDR, -> CAP_Y; else stay.
- CAP_Y: ram_out1<=shadow_x, ram_out2<=mem_rdata, frame_data_valid<=1 (visible the next cycle, for exactly 1 clk), -> IDLE. Port is free for the CPU.

Arbitration (in REQ_X/REQ_Y only):
- VGA wins iff cpu_req=0 or wait_cnt==TIMEOUT.
- In all other states the CPU wins whenever cpu_req=1.
- When the CPU wins, mem_addr/mem_we/mem_wdata come from the cpu_* inputs and cpu_grant=1.
- When nobody requests: mem_we=0, mem_addr=0.

wait_cnt:
- Increments each cycle in REQ_X/REQ_Y where the CPU wins.
- Saturates at TIMEOUT and is not cleared between X and Y, so starvation priority persists for the rest of the fetch.

CPU handshake:
- The CPU holds cpu_req and its inputs until it sees cpu_grant=1. A denied request has no side effect.
- cpu_rvalid is asserted the cycle after a granted read, never after a write.

Best-case latency: frame_start at cycle N gives X issue at N+1, Y issue at N+3, outputs updated and frame_data_valid high at N+5.

Boundary conditions:
- frame_start in any non-IDLE state: ignored, fetch_overrun<=1 (sticky until reset), current fetch continues.
- frame_start in the same cycle as the CAP_Y->IDLE transition: counts as overrun and is not restarted.
- ram_out1/ram_out2 only ever change together in CAP_Y; a partial fetch never reaches the outputs.
- Reset mid-fetch: returns to IDLE and outputs revert to their reset values; the next frame_start starts a fresh fetch.
- CPU writes to SHIP_X_ADDR/SHIP_Y_ADDR between the two VGA issues are allowed. The VGA pair then reflects X before the write and Y after it; this is accepted by design.

Test Plan:
- Reset: after release, ram_out1=0000 and ram_out2=1000; frame_data_valid, fetch_overrun and cpu_rvalid are all 0.
- Idle CPU: RAM[3FF0]=0064, RAM[3FF1]=00C8; pulse frame_start at N -> at N+5 ram_out1=0064, ram_out2=00C8, frame_data_valid high exactly 1 clk.
- CPU contention: cpu_req held 10 cycles after frame_start with TIMEOUT=64 -> cpu_grant=1 throughout; VGA X issued the first cycle cpu_req drops; outputs update 4 cycles later.
- Starvation: cpu_req held permanently -> VGA X issued once wait_cnt hits 64, and Y issued at the next REQ_Y cycle; cpu_grant=0 on exactly those 2 issue cycles.
- Overrun: second frame_start 2 cycles after the first -> fetch_overrun=1 and stays high; only one frame_data_valid pulse; outputs hold the first fetch's data.
- Async reset: assert reset while in REQ_Y -> outputs immediately 0000/1000 and state IDLE; a new frame_start with RAM[3FF1]=0400 yields ram_out2=0400 (dead screen).
